cross_rx: RTL and testbench

- Read-side consumer for the dual-clock data FIFO, running entirely in the read clock domain.
- Pops words from the FIFO's read port (standard mode, 1-cycle read latency) and presents them downstream over a valid/ready handshake.
- A 2-entry skid buffer sustains one word per cycle under backpressure.
- Also keeps a held copy of the most recently delivered value, plus a delivered-word counter, for status readout.

---
 rtl/cross_rx_if.sv | 19 +
 rtl/cross_rx.sv | 45 ++++
 tb/tb_cross_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cross_rx_if.sv
// cross_rx_if: FIFO read port plus downstream valid/ready stream and status readout.
interface cross_rx_if #(parameter int WIDTH = 24);
  logic             rdempty;
  logic [WIDTH-1:0] q;
  logic             rdreq;
  logic [WIDTH-1:0] dataOut;
  logic             dataValid;
  logic             dataReady;
  logic [WIDTH-1:0] lastValue;
  logic [15:0]      wordCount;
  modport master (
    input  rdempty, q, dataReady,
    output rdreq, dataOut, dataValid, lastValue, wordCount
  );
  modport slave (
    output rdempty, q, dataReady,
    input  rdreq, dataOut, dataValid, lastValue, wordCount
  );
endinterface

// File: rtl/cross_rx.sv
// cross_rx: read-domain FIFO consumer feeding a 2-entry skid buffer onto a valid/ready stream.
module cross_rx #(parameter int WIDTH = 24) (
  input logic        clk,
  input logic        reset,
  cross_rx_if.master bus
);
  logic [1:0]       occ, occ_n;
  logic             inflight, accept;
  logic [2:0]       lvl;
  logic [WIDTH-1:0] head, skid, head_n, skid_n, last;
  logic [15:0]      cnt;
  assign accept = |occ & bus.dataReady;
  // Entries the buffer will hold after this cycle; a pop is only safe if one slot stays free.
  assign lvl = 3'(occ) + 3'(inflight) - 3'(accept);
  assign bus.rdreq = ~reset & ~bus.rdempty & (lvl < 3'd2);
  always_comb begin
    occ_n  = occ + 2'(inflight) - 2'(accept);
    head_n = (accept & occ == 2'd2) ? skid :
             (inflight & (occ == 2'd0 | (accept & occ == 2'd1))) ? bus.q : head;
    skid_n = (inflight & ((occ == 2'd1 & ~accept) | (occ == 2'd2 & accept))) ? bus.q : skid;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      skid     <= '0;
      last     <= '0;
      cnt      <= '0;
    end else begin
      occ      <= occ_n;
      inflight <= bus.rdreq;
      head     <= head_n;
      skid     <= skid_n;
      if (accept) begin
        last <= head;
        cnt  <= cnt + 16'd1;
      end
    end
  end
  assign bus.dataOut   = head;
  assign bus.dataValid = |occ;
  assign bus.lastValue = last;
  assign bus.wordCount = cnt;
endmodule

// File: tb/tb_cross_rx.sv
// tb_cross_rx: directed checks of cross_rx against a behavioural 1-cycle-latency FIFO.
module tb_cross_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   wp = 0;
  int   rp = 0;
  int   viol = 0;
  logic [23:0] mem [0:131071];
  logic [23:0] got [$];
  cross_rx_if #(.WIDTH(24)) bus ();
  cross_rx #(.WIDTH(24)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.rdempty = (rp == wp);
  always @(posedge clk) begin
    if (bus.rdreq && bus.rdempty) viol <= viol + 1;
    if (bus.rdreq) begin
      bus.q <= mem[rp];
      rp    <= rp + 1;
    end
    if (bus.dataValid && bus.dataReady) got.push_back(bus.dataOut);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [23:0] v);
    mem[wp] = v;
    wp++;
  endtask
  initial begin
    int n;
    bus.dataReady = 1'b0;
    bus.q = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.dataValid), 0);
    chk("rst_rdreq", 32'(bus.rdreq), 0);
    chk("rst_dataout", 32'(bus.dataOut), 0);
    chk("rst_last", 32'(bus.lastValue), 0);
    chk("rst_count", 32'(bus.wordCount), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rdreq", 32'(bus.rdreq), 0);
    push(24'hABCDEF);
    bus.dataReady = 1'b1;
    #1 chk("single_rdreq_c0", 32'(bus.rdreq), 1);
    @(negedge clk);
    chk("single_valid_c1", 32'(bus.dataValid), 0);
    @(negedge clk);
    chk("single_valid_c2", 32'(bus.dataValid), 1);
    chk("single_data_c2", 32'(bus.dataOut), 32'hABCDEF);
    @(negedge clk);
    chk("single_valid_c3", 32'(bus.dataValid), 0);
    chk("single_hold_data", 32'(bus.dataOut), 32'hABCDEF);
    chk("single_last", 32'(bus.lastValue), 32'hABCDEF);
    chk("single_count", 32'(bus.wordCount), 1);
    got.delete();
    for (int i = 1; i <= 8; i++) push(24'(i));
    repeat (9) @(negedge clk);
    chk("stream_size_e9", got.size(), 7);
    @(negedge clk);
    chk("stream_size_e10", got.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("stream_word%0d", i), 32'(got[i]), 32'(i + 1));
    chk("stream_count", 32'(bus.wordCount), 9);
    chk("stream_last", 32'(bus.lastValue), 8);
    repeat (2) @(negedge clk);
    bus.dataReady = 1'b0;
    got.delete();
    for (int i = 1; i <= 4; i++) push(24'(i));
    repeat (4) @(negedge clk);
    chk("bp_rdreq", 32'(bus.rdreq), 0);
    chk("bp_rdempty", 32'(bus.rdempty), 0);
    chk("bp_valid", 32'(bus.dataValid), 1);
    chk("bp_data_a", 32'(bus.dataOut), 1);
    repeat (3) @(negedge clk);
    chk("bp_data_b", 32'(bus.dataOut), 1);
    chk("bp_none_taken", got.size(), 0);
    bus.dataReady = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_size_e3", got.size(), 3);
    @(negedge clk);
    chk("bp_size_e4", got.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_word%0d", i), 32'(got[i]), 32'(i + 1));
    chk("bp_count", 32'(bus.wordCount), 13);
    repeat (2) @(negedge clk);
    got.delete();
    for (int i = 0; i < 8; i++) push(24'h10 + 24'(i));
    repeat (3) @(negedge clk);
    chk("mr_pre_size", got.size(), 1);
    #1 reset = 1'b1;
    #1;
    chk("mr_valid", 32'(bus.dataValid), 0);
    chk("mr_data", 32'(bus.dataOut), 0);
    chk("mr_last", 32'(bus.lastValue), 0);
    chk("mr_count", 32'(bus.wordCount), 0);
    chk("mr_rdreq", 32'(bus.rdreq), 0);
    got.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mr_size", got.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("mr_word%0d", i), 32'(got[i]), 32'h13 + 32'(i));
    chk("mr_count_after", 32'(bus.wordCount), 5);
    got.delete();
    for (int i = 0; i < 65530; i++) push(24'(i));
    n = 0;
    while (!(rp == wp && !bus.dataValid) && n < 70000) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_timeout", 32'(n < 70000), 1);
    repeat (3) @(negedge clk);
    chk("wrap_size", got.size(), 65530);
    chk("wrap_count_ffff", 32'(bus.wordCount), 32'hFFFF);
    chk("wrap_last_pre", 32'(bus.lastValue), 32'd65529);
    push(24'h5A5A5A);
    repeat (4) @(negedge clk);
    chk("wrap_count_zero", 32'(bus.wordCount), 0);
    chk("wrap_last", 32'(bus.lastValue), 32'h5A5A5A);
    chk("no_pop_when_empty", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
